// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: receive FIFO with interrupt/retry FSM toward the core,
// plus a one-word output holding register with overrun detection.
module io_irq_ctrl #(
  parameter int DEPTH = 4,
  parameter int RETRY = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dev_in_data,
  input  logic        dev_in_valid,
  output logic        dev_in_ready,
  output logic [15:0] data_in,
  output logic        interrupt,
  input  logic        rd_ack,
  input  logic [15:0] data_out,
  input  logic        wr_strobe,
  output logic [15:0] dev_out_data,
  output logic        dev_out_valid,
  input  logic        dev_out_ready,
  output logic        ovr
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RETRY + 1);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state, state_nx;
  logic [RW-1:0] retry;
  logic          push, pop, accept;

  assign dev_in_ready = count != (AW+1)'(DEPTH);
  assign data_in      = count != '0 ? mem[rd_ptr] : 16'h0000;
  assign push         = dev_in_valid & dev_in_ready;
  assign pop          = rd_ack & (count != '0);
  assign accept       = wr_strobe & (~dev_out_valid | dev_out_ready);

  // a pop always wins over any pending request transition
  assign state_nx = state == IDLE ? ((count != '0 && !pop) ? REQ : IDLE)
                  : state == REQ  ? (pop ? IDLE : WAIT)
                  : pop ? IDLE : (retry == RW'(RETRY - 1) ? REQ : WAIT);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= dev_in_data;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      retry     <= '0;
      interrupt <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= count + (AW+1)'(push) - (AW+1)'(pop);
      state     <= state_nx;
      retry     <= (state == WAIT && state_nx == WAIT) ? retry + 1'b1 : '0;
      interrupt <= state_nx == REQ;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dev_out_data  <= 16'h0000;
      dev_out_valid <= 1'b0;
      ovr           <= 1'b0;
    end else begin
      if (accept) dev_out_data <= data_out;
      dev_out_valid <= accept | (dev_out_valid & ~dev_out_ready);
      if (wr_strobe & dev_out_valid & ~dev_out_ready) ovr <= 1'b1;
    end
endmodule
